// File: rtl/poci_uart.sv
// rtl/poci_uart.sv - POCI slave UART: TX/RX FIFOs, serialiser, deserialiser, programmable bit period.
// Define POCI_UART_PARITY_EN for 8E1 framing (even parity) in both directions; default is 8N1.
module poci_uart #(
  parameter int CLK_HZ   = 24000000,
  parameter int BAUD     = 115200,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  localparam logic [15:0] DIV_RESET = 16'(CLK_HZ / BAUD);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT} rx_state_t;

  logic [1:0] reg_sel;
  logic       access, data_wr, data_rd, status_wr, div_wr;
  logic       unused_bits;

  assign reg_sel     = paddr[3:2];
  assign access      = psel & penable;
  assign data_wr     = access &  pwrite & (reg_sel == 2'd0);
  assign data_rd     = access & ~pwrite & (reg_sel == 2'd0);
  assign status_wr   = access &  pwrite & (reg_sel == 2'd1);
  assign div_wr      = access &  pwrite & (reg_sel == 2'd2);
  assign pready      = 1'b1;
  assign unused_bits = ^{pwdata[31:16], paddr[1:0]};

  logic [15:0] div_reg;

  always_ff @(posedge pclk) begin
    if (reset)
      div_reg <= DIV_RESET;
    else if (div_wr)
      div_reg <= (pwdata[15:0] < 16'd4) ? 16'd4 : pwdata[15:0];
  end

  // TX FIFO
  logic [7:0] tx_mem [TX_DEPTH];
  logic [TAW:0] tx_wptr, tx_rptr;
  logic tx_empty, tx_full, tx_load, tx_push, tx_ovf_set;
  logic [7:0] tx_head;

  assign tx_empty   = (tx_wptr == tx_rptr);
  assign tx_full    = (tx_wptr[TAW] != tx_rptr[TAW]) && (tx_wptr[TAW-1:0] == tx_rptr[TAW-1:0]);
  assign tx_head    = tx_mem[tx_rptr[TAW-1:0]];
  assign tx_push    = data_wr & (~tx_full | tx_load);
  assign tx_ovf_set = data_wr & tx_full & ~tx_load;

  always_ff @(posedge pclk) begin
    if (tx_push)
      tx_mem[tx_wptr[TAW-1:0]] <= pwdata[7:0];
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_load) tx_rptr <= tx_rptr + 1'b1;
    end
  end

  // TX serialiser
  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        tx_idle;
`ifdef POCI_UART_PARITY_EN
  logic        tx_par;
`endif

  // Leaving STOP with data queued reloads directly so frames stay back-to-back.
  assign tx_load = ~tx_empty & ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & (tx_cnt == 16'd0)));
  assign tx_idle = tx_empty & (tx_state == TX_IDLE);

  always_ff @(posedge pclk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      uart_txd <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
`ifdef POCI_UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tx_load) begin
      tx_sh    <= tx_head;
`ifdef POCI_UART_PARITY_EN
      tx_par   <= ^tx_head;
`endif
      uart_txd <= 1'b0;
      tx_cnt   <= div_reg - 16'd1;
      tx_state <= TX_START;
    end else begin
      if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
      case (tx_state)
        TX_IDLE: uart_txd <= 1'b1;
        TX_START: begin
          if (tx_cnt == 16'd0) begin
            uart_txd <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
            tx_bit   <= '0;
            tx_cnt   <= div_reg - 16'd1;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= div_reg - 16'd1;
            if (tx_bit == 3'd7) begin
`ifdef POCI_UART_PARITY_EN
              uart_txd <= tx_par;
              tx_state <= TX_PAR;
`else
              uart_txd <= 1'b1;
              tx_state <= TX_STOP;
`endif
            end else begin
              uart_txd <= tx_sh[0];
              tx_sh    <= {1'b0, tx_sh[7:1]};
              tx_bit   <= tx_bit + 3'd1;
            end
          end
        end
`ifdef POCI_UART_PARITY_EN
        TX_PAR: begin
          if (tx_cnt == 16'd0) begin
            uart_txd <= 1'b1;
            tx_cnt   <= div_reg - 16'd1;
            tx_state <= TX_STOP;
          end
        end
`endif
        TX_STOP: begin
          if (tx_cnt == 16'd0) begin
            uart_txd <= 1'b1;
            tx_state <= TX_IDLE;
          end
        end
        default: begin
          uart_txd <= 1'b1;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // RX synchroniser and edge history
  logic [1:0] rx_sync;
  logic       rx_s, rx_prev;

  assign rx_s = rx_sync[1];

  always_ff @(posedge pclk) begin
    if (reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], uart_rxd};
      rx_prev <= rx_s;
    end
  end

  // RX deserialiser
  rx_state_t   rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_push, frame_err_set;
`ifdef POCI_UART_PARITY_EN
  logic        rx_par_bad;
`endif

  assign rx_push       = (rx_state == RX_STOP) & (rx_cnt == 16'd0) &  rx_s;
  assign frame_err_set = (rx_state == RX_STOP) & (rx_cnt == 16'd0) & ~rx_s;

  always_ff @(posedge pclk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
`ifdef POCI_UART_PARITY_EN
      rx_par_bad <= 1'b0;
`endif
    end else begin
      if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev & ~rx_s) begin
            rx_cnt   <= {1'b0, div_reg[15:1]} - 16'd1;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == 16'd0) begin
            if (rx_s) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_bit   <= '0;
              rx_cnt   <= div_reg - 16'd1;
              rx_state <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_sh  <= {rx_s, rx_sh[7:1]};
            rx_cnt <= div_reg - 16'd1;
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) begin
`ifdef POCI_UART_PARITY_EN
              rx_state <= RX_PAR;
`else
              rx_state <= RX_STOP;
`endif
            end
          end
        end
`ifdef POCI_UART_PARITY_EN
        RX_PAR: begin
          if (rx_cnt == 16'd0) begin
            rx_par_bad <= rx_s ^ (^rx_sh);
            rx_cnt     <= div_reg - 16'd1;
            rx_state   <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (rx_cnt == 16'd0)
            rx_state <= rx_s ? RX_IDLE : RX_WAIT;
        end
        RX_WAIT: begin
          if (rx_s) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // RX FIFO
  logic [7:0] rx_mem [RX_DEPTH];
  logic [RAW:0] rx_wptr, rx_rptr;
  logic rx_empty, rx_full, rx_pop, rx_accept, rx_ovr_set;
  logic [7:0] rx_head;

  assign rx_empty   = (rx_wptr == rx_rptr);
  assign rx_full    = (rx_wptr[RAW] != rx_rptr[RAW]) && (rx_wptr[RAW-1:0] == rx_rptr[RAW-1:0]);
  assign rx_head    = rx_mem[rx_rptr[RAW-1:0]];
  assign rx_pop     = data_rd & ~rx_empty;
  assign rx_accept  = rx_push & (~rx_full | rx_pop);
  assign rx_ovr_set = rx_push & rx_full & ~rx_pop;

  always_ff @(posedge pclk) begin
    if (rx_accept)
      rx_mem[rx_wptr[RAW-1:0]] <= rx_sh;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (rx_accept) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)    rx_rptr <= rx_rptr + 1'b1;
    end
  end

  // Sticky status; a set in the same cycle as a clear wins.
  logic rx_ovr, frame_err, tx_ovf, parity_err;

  always_ff @(posedge pclk) begin
    if (reset) begin
      rx_ovr    <= 1'b0;
      frame_err <= 1'b0;
      tx_ovf    <= 1'b0;
    end else begin
      rx_ovr    <= rx_ovr_set    | (rx_ovr    & ~(status_wr & pwdata[4]));
      frame_err <= frame_err_set | (frame_err & ~(status_wr & pwdata[5]));
      tx_ovf    <= tx_ovf_set    | (tx_ovf    & ~(status_wr & pwdata[6]));
    end
  end

`ifdef POCI_UART_PARITY_EN
  always_ff @(posedge pclk) begin
    if (reset)
      parity_err <= 1'b0;
    else
      parity_err <= (rx_push & rx_par_bad) | (parity_err & ~(status_wr & pwdata[7]));
  end
`else
  assign parity_err = 1'b0;
`endif

  logic [7:0] status;
  assign status = {parity_err, tx_ovf, frame_err, rx_ovr, rx_full, ~rx_empty, tx_idle, tx_full};

  always_comb begin
    prdata = '0;
    if (psel) begin
      case (reg_sel)
        2'd0: if (!rx_empty) prdata = {23'b0, 1'b1, rx_head};
        2'd1: prdata = {24'b0, status};
        2'd2: prdata = {16'b0, div_reg};
        default: prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_poci_uart.sv
// tb/tb_poci_uart.sv - self-checking bench for poci_uart against a frame-level reference model.
// Define POCI_UART_PARITY_EN here too to exercise the 8E1 build.
module tb_poci_uart;

  typedef bit bitq_t[$];

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [3:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        uart_txd;
  logic        uart_rxd = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  bit txlog[$];
  int last_wr_idx;

  poci_uart dut (
    .pclk(pclk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .uart_txd(uart_txd), .uart_rxd(uart_rxd)
  );

  always #5 pclk = ~pclk;

  // One entry per cycle: the line value after each rising edge.
  always @(negedge pclk) txlog.push_back(uart_txd);

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    last_wr_idx = txlog.size();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge pclk); #1;
    penable = 1'b1;
    #3 d = prdata;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  function automatic bitq_t frame_bits(input logic [7:0] b, input bit stop_bit);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
`ifdef POCI_UART_PARITY_EN
    q.push_back(^b);
`endif
    q.push_back(stop_bit);
    return q;
  endfunction

  function automatic bitq_t append_bits(input bitq_t a, input bitq_t b, input int div);
    bitq_t q;
    q = a;
    foreach (b[i]) for (int k = 0; k < div; k++) q.push_back(b[i]);
    return q;
  endfunction

  task automatic send_bits(input bitq_t bits, input int div);
    @(posedge pclk); #1;
    foreach (bits[i]) begin
      uart_rxd = bits[i];
      repeat (div) @(posedge pclk);
      #1;
    end
    uart_rxd = 1'b1;
    repeat (div) @(posedge pclk);
    #1;
  endtask

  function automatic int frame_len();
`ifdef POCI_UART_PARITY_EN
    return 11;
`else
    return 10;
`endif
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    vectors++;
    if (uart_txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd got %b exp 1", uart_txd); end
    vectors++;
    if (prdata !== 32'h0) begin miscompares++; $display("FAIL reset_prdata got %h exp 0", prdata); end
    reset = 1'b0;
    apb_read(4'h8, d);
    vectors++;
    if (d !== 32'd208) begin miscompares++; $display("FAIL reset_divisor got %0d exp 208", d); end
    apb_read(4'h4, d);
    vectors++;
    if (d !== 32'h2) begin miscompares++; $display("FAIL reset_status got %h exp 2", d); end
    apb_read(4'h0, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h exp 0", d); end
    apb_read(4'hC, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reg_c got %h exp 0", d); end
  endtask

  task automatic test_divisor();
    logic [31:0] d;
    apb_write(4'h8, 32'd3);
    apb_read(4'h8, d);
    vectors++;
    if (d !== 32'd4) begin miscompares++; $display("FAIL div_clamp got %0d exp 4", d); end
    apb_write(4'h8, 32'hABCD_0008);
    apb_read(4'h8, d);
    vectors++;
    if (d !== 32'd8) begin miscompares++; $display("FAIL div_write got %0d exp 8", d); end
  endtask

  task automatic test_tx_single(input logic [7:0] b, input string name);
    logic [31:0] d;
    bitq_t exp_w;
    int base, bad;
    apb_write(4'h0, {24'h0, b});
    base = last_wr_idx;
    repeat (40) @(posedge pclk);
    apb_read(4'h4, d);
    vectors++;
    if (d[1] !== 1'b0) begin miscompares++; $display("FAIL %s busy_idle got %b exp 0", name, d[1]); end
    repeat (60) @(posedge pclk);
    apb_read(4'h4, d);
    vectors++;
    if (d !== 32'h2) begin miscompares++; $display("FAIL %s done_status got %h exp 2", name, d); end
    exp_w.push_back(1'b1);
    exp_w = append_bits(exp_w, frame_bits(b, 1'b1), 8);
    exp_w.push_back(1'b1);
    exp_w.push_back(1'b1);
    bad = -1;
    if (txlog.size() < base + exp_w.size()) bad = -2;
    else foreach (exp_w[i]) if (bad == -1 && txlog[base + i] !== exp_w[i]) bad = i;
    vectors++;
    if (bad != -1) begin miscompares++; $display("FAIL %s wave first_bad_bit got %0d exp -1", name, bad); end
`ifdef POCI_UART_PARITY_EN
    vectors++;
    if (txlog[base + 1 + 9 * 8 + 4] !== ^b) begin
      miscompares++; $display("FAIL %s parity_bit got %b exp %b", name, txlog[base + 1 + 9 * 8 + 4], ^b);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0] bytes [6];
    bitq_t exp_w;
    int base, bad;
    for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
    apb_write(4'h0, {24'h0, bytes[0]});
    base = last_wr_idx;
    for (int i = 1; i < 6; i++) apb_write(4'h0, {24'h0, bytes[i]});
    apb_read(4'h4, d);
    vectors++;
    if (d !== 32'h41) begin miscompares++; $display("FAIL b2b_ovf_status got %h exp 41", d); end
    apb_write(4'h4, 32'h40);
    apb_read(4'h4, d);
    vectors++;
    if (d !== 32'h01) begin miscompares++; $display("FAIL b2b_clear_status got %h exp 01", d); end
    repeat (5 * 8 * frame_len() + 20) @(posedge pclk);
    exp_w.push_back(1'b1);
    for (int i = 0; i < 5; i++) exp_w = append_bits(exp_w, frame_bits(bytes[i], 1'b1), 8);
    exp_w.push_back(1'b1);
    exp_w.push_back(1'b1);
    bad = -1;
    if (txlog.size() < base + exp_w.size()) bad = -2;
    else foreach (exp_w[i]) if (bad == -1 && txlog[base + i] !== exp_w[i]) bad = i;
    vectors++;
    if (bad != -1) begin miscompares++; $display("FAIL b2b_wave first_bad_bit got %0d exp -1", bad); end
    apb_read(4'h4, d);
    vectors++;
    if (d !== 32'h2) begin miscompares++; $display("FAIL b2b_done_status got %h exp 2", d); end
  endtask

  task automatic test_rx_basic();
    logic [31:0] d;
    send_bits(frame_bits(8'h3C, 1'b1), 8);
    apb_read(4'h4, d);
    vectors++;
    if (d !== 32'h6) begin miscompares++; $display("FAIL rx_status got %h exp 6", d); end
    apb_read(4'h0, d);
    vectors++;
    if (d !== 32'h13C) begin miscompares++; $display("FAIL rx_data got %h exp 13c", d); end
    apb_read(4'h0, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL rx_empty_read got %h exp 0", d); end
  endtask

  task automatic test_rx_overflow();
    logic [31:0] d;
    logic [7:0] b;
    logic [7:0] model[$];
    bit ovr;
    ovr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      if (model.size() < 4) model.push_back(b); else ovr = 1'b1;
      send_bits(frame_bits(b, 1'b1), 8);
    end
    apb_read(4'h4, d);
    vectors++;
    if (d !== {24'h0, 3'b000, ovr, 4'b1110}) begin
      miscompares++; $display("FAIL rx_ovr_status got %h exp %h", d, {24'h0, 3'b000, ovr, 4'b1110});
    end
    while (model.size() > 0) begin
      apb_read(4'h0, d);
      vectors++;
      if (d !== {23'h0, 1'b1, model[0]}) begin
        miscompares++; $display("FAIL rx_fifo_order got %h exp %h", d, {23'h0, 1'b1, model[0]});
      end
      void'(model.pop_front());
    end
    apb_write(4'h4, 32'h10);
    apb_read(4'h4, d);
    vectors++;
    if (d !== 32'h2) begin miscompares++; $display("FAIL rx_ovr_clear got %h exp 2", d); end
  endtask

  task automatic test_rx_errors();
    logic [31:0] d;
    logic [7:0] b;
    @(posedge pclk); #1 uart_rxd = 1'b0;
    @(posedge pclk); #1 uart_rxd = 1'b1;
    repeat (30) @(posedge pclk);
    apb_read(4'h4, d);
    vectors++;
    if (d !== 32'h2) begin miscompares++; $display("FAIL glitch_status got %h exp 2", d); end
    b = 8'($urandom);
    send_bits(frame_bits(b, 1'b0), 8);
    apb_read(4'h4, d);
    vectors++;
    if (d !== 32'h22) begin miscompares++; $display("FAIL frame_err_status got %h exp 22", d); end
    apb_read(4'h0, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL frame_err_data got %h exp 0", d); end
    apb_write(4'h4, 32'h20);
    b = 8'($urandom);
    send_bits(frame_bits(b, 1'b1), 8);
    apb_read(4'h0, d);
    vectors++;
    if (d !== {23'h0, 1'b1, b}) begin miscompares++; $display("FAIL rx_recover got %h exp %h", d, {23'h0, 1'b1, b}); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [7:0] b;
    bitq_t exp_w;
    int div, base, bad;
    for (int it = 0; it < 4; it++) begin
      div = $urandom_range(4, 12);
      apb_write(4'h8, div);
      b = 8'($urandom);
      apb_write(4'h0, {24'h0, b});
      base = last_wr_idx;
      repeat (div * frame_len() + 6) @(posedge pclk);
      exp_w = {};
      exp_w.push_back(1'b1);
      exp_w = append_bits(exp_w, frame_bits(b, 1'b1), div);
      exp_w.push_back(1'b1);
      bad = -1;
      if (txlog.size() < base + exp_w.size()) bad = -2;
      else foreach (exp_w[i]) if (bad == -1 && txlog[base + i] !== exp_w[i]) bad = i;
      vectors++;
      if (bad != -1) begin miscompares++; $display("FAIL rand_tx div %0d first_bad_bit got %0d exp -1", div, bad); end
      b = 8'($urandom);
      send_bits(frame_bits(b, 1'b1), div);
      apb_read(4'h0, d);
      vectors++;
      if (d !== {23'h0, 1'b1, b}) begin
        miscompares++; $display("FAIL rand_rx div %0d got %h exp %h", div, d, {23'h0, 1'b1, b});
      end
    end
    apb_write(4'h8, 32'd8);
  endtask

`ifdef POCI_UART_PARITY_EN
  task automatic test_parity();
    logic [31:0] d;
    logic [7:0] b;
    bitq_t q;
    test_tx_single(8'h07, "tx_parity_07");
    b = 8'($urandom);
    q = frame_bits(b, 1'b1);
    q[9] = ~q[9];
    send_bits(q, 8);
    apb_read(4'h4, d);
    vectors++;
    if (d !== 32'h86) begin miscompares++; $display("FAIL parity_err_status got %h exp 86", d); end
    apb_read(4'h0, d);
    vectors++;
    if (d !== {23'h0, 1'b1, b}) begin miscompares++; $display("FAIL parity_err_data got %h exp %h", d, {23'h0, 1'b1, b}); end
    apb_write(4'h4, 32'h80);
  endtask
`endif

  task automatic test_reset_midframe();
    logic [31:0] d;
    apb_write(4'h0, 32'hFF);
    repeat (30) @(posedge pclk);
    #1 uart_rxd = 1'b0;
    repeat (10) @(posedge pclk);
    #1 reset = 1'b1;
    uart_rxd = 1'b1;
    @(negedge pclk);
    vectors++;
    if (uart_txd !== 1'b1) begin miscompares++; $display("FAIL midframe_txd got %b exp 1", uart_txd); end
    repeat (2) @(posedge pclk);
    #1 reset = 1'b0;
    repeat (20) @(posedge pclk);
    apb_read(4'h4, d);
    vectors++;
    if (d !== 32'h2) begin miscompares++; $display("FAIL midframe_status got %h exp 2", d); end
    apb_read(4'h8, d);
    vectors++;
    if (d !== 32'd208) begin miscompares++; $display("FAIL midframe_divisor got %0d exp 208", d); end
    apb_read(4'h0, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL midframe_rx got %h exp 0", d); end
  endtask

  initial begin
    test_reset();
    test_divisor();
    test_tx_single(8'hA5, "tx_a5");
    test_back_to_back();
    test_rx_basic();
    test_rx_overflow();
    test_rx_errors();
    test_random();
`ifdef POCI_UART_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
